// File: rtl/mem_access_unit_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : mem_access_unit_if
// Description : Request/response and RAM-side signal bundle of the data-memory
//               responder. The slave modport is the responder's view; the
//               master modport is the view of the requester plus the RAM.
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_access_unit_if #(
   parameter int ADDR_W = 10
) ();
   logic              req_valid;
   logic              req_ready;
   logic              memRead;
   logic              memWrite;
   logic [1:0]        memDataSize;
   logic              memBitExt;
   logic [31:0]       addr;
   logic [31:0]       wdata;
   logic [31:0]       rdata;
   logic              done;
   logic              err;
   logic              ram_en;
   logic              ram_we;
   logic [ADDR_W-1:0] ram_addr;
   logic [31:0]       ram_wdata;
   logic [31:0]       ram_rdata;

   modport master (
      output req_valid, memRead, memWrite, memDataSize, memBitExt, addr, wdata,
      output ram_rdata,
      input  req_ready, rdata, done, err,
      input  ram_en, ram_we, ram_addr, ram_wdata
   );

   modport slave (
      input  req_valid, memRead, memWrite, memDataSize, memBitExt, addr, wdata,
      input  ram_rdata,
      output req_ready, rdata, done, err,
      output ram_en, ram_we, ram_addr, ram_wdata
   );
endinterface
`default_nettype wire

// File: rtl/mem_access_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : mem_access_unit
// Description : Data-memory responder for a MIPS32 core. Performs word,
//               halfword and byte loads/stores against a word-wide synchronous
//               RAM without byte enables. Sub-word stores are done as
//               read-modify-write; loads are sign/zero extended.
//               Optional macro MEM_ALIGN_CHECK_EN rejects misaligned halfword
//               and word accesses with err.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_unit #(
   parameter int ADDR_W = 10
) (
   input  logic                  clk,
   input  logic                  rst_n,
   mem_access_unit_if.slave      bus
);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_RD   = 3'd1;
   localparam logic [2:0] S_RDW  = 3'd2;
   localparam logic [2:0] S_WR   = 3'd3;
   localparam logic [2:0] S_DONE = 3'd4;

   logic [2:0]        state;
   logic [2:0]        state_nxt;

   // Latched request
   logic              op_wr;
   logic [1:0]        size_r;
   logic              ext_r;
   logic [1:0]        lane_r;
   logic [ADDR_W-1:0] addr_r;
   logic              err_r;
   // Holds latched store data, then the merged word for sub-word stores
   logic [31:0]       wword_r;
   logic [31:0]       rdata_r;

   logic              accept;
   logic              req_err;
   logic              misaligned;
   logic              req_is_word;
   logic              req_is_half;
   logic [31:0]       load_word;
   logic [31:0]       merge_word;
   logic [7:0]        byte_sel;
   logic [15:0]       half_sel;

   assign req_is_word = (bus.memDataSize == 2'd0) || (bus.memDataSize == 2'd3);
   assign req_is_half = (bus.memDataSize == 2'd1);
   // A request with neither read nor write is never accepted
   assign accept      = (state == S_IDLE) && bus.req_valid && (bus.memRead || bus.memWrite);

`ifdef MEM_ALIGN_CHECK_EN
   assign misaligned  = (req_is_half && bus.addr[0]) || (req_is_word && (bus.addr[1:0] != 2'b00));
`else
   assign misaligned  = 1'b0;
`endif
   assign req_err     = (bus.memRead && bus.memWrite) || misaligned;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   // Next-state decode
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (accept) begin
               if (req_err)           state_nxt = S_DONE;
               else if (bus.memRead)  state_nxt = S_RD;
               else if (req_is_word)  state_nxt = S_WR;
               else                   state_nxt = S_RD;
            end
         end
         S_RD:    state_nxt = S_RDW;
         S_RDW:   state_nxt = op_wr ? S_WR : S_DONE;
         S_WR:    state_nxt = S_DONE;
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Outputs decoded from state; address/data come straight from registers
   always_comb begin
      bus.req_ready = (state == S_IDLE);
      bus.ram_en    = (state == S_RD) || (state == S_WR);
      bus.ram_we    = (state == S_WR);
      bus.done      = (state == S_DONE);
      bus.err       = (state == S_DONE) && err_r;
   end

   assign bus.ram_addr  = addr_r;
   assign bus.ram_wdata = wword_r;
   assign bus.rdata     = rdata_r;

   // Lane extraction and extension of the returned RAM word for loads
   always_comb begin
      byte_sel  = bus.ram_rdata[{lane_r, 3'b000} +: 8];
      half_sel  = lane_r[1] ? bus.ram_rdata[31:16] : bus.ram_rdata[15:0];
      case (size_r)
         2'd1:    load_word = {{16{!ext_r && half_sel[15]}}, half_sel};
         2'd2:    load_word = {{24{!ext_r && byte_sel[7]}}, byte_sel};
         default: load_word = bus.ram_rdata;
      endcase
   end

   // Insert the low store bits into the addressed lane of the RAM word
   always_comb begin
      merge_word = bus.ram_rdata;
      case (size_r)
         2'd1: begin
            if (lane_r[1]) merge_word[31:16] = wword_r[15:0];
            else           merge_word[15:0]  = wword_r[15:0];
         end
         2'd2:    merge_word[{lane_r, 3'b000} +: 8] = wword_r[7:0];
         default: merge_word = wword_r;
      endcase
   end

   // Request latch, merge register and load result register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_wr   <= 1'b0;
         size_r  <= 2'd0;
         ext_r   <= 1'b0;
         lane_r  <= 2'd0;
         addr_r  <= '0;
         err_r   <= 1'b0;
         wword_r <= 32'd0;
         rdata_r <= 32'd0;
      end else if (accept) begin
         op_wr   <= bus.memWrite;
         size_r  <= bus.memDataSize;
         ext_r   <= bus.memBitExt;
         lane_r  <= bus.addr[1:0];
         addr_r  <= bus.addr[ADDR_W+1:2];
         err_r   <= req_err;
         wword_r <= bus.wdata;
      end else if (state == S_RDW) begin
         if (op_wr) wword_r <= merge_word;
         else       rdata_r <= load_word;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_mem_access_unit
// Description : Self-checking bench for mem_access_unit with a word RAM,
//               a request-level reference model and a per-cycle comparator.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_unit;
   localparam int ADDR_W = 10;
   localparam int DEPTH  = 1 << ADDR_W;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   mem_access_unit_if #(.ADDR_W(ADDR_W)) bus ();

   mem_access_unit #(.ADDR_W(ADDR_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Backing synchronous RAM
   logic [31:0] ram [0:DEPTH-1];
   always @(posedge clk) begin
      if (bus.ram_en) begin
         if (bus.ram_we) ram[bus.ram_addr] <= bus.ram_wdata;
         else            bus.ram_rdata     <= ram[bus.ram_addr];
      end
   end

   // Reference model state
   typedef struct {
      bit                ready;
      bit                en;
      bit                we;
      bit                done;
      bit                err;
      logic [31:0]       rdata;
      logic [ADDR_W-1:0] a;
      logic [31:0]       wd;
   } exp_t;

   exp_t        expq[$];
   exp_t        cur;
   logic [31:0] ref_mem [0:DEPTH-1];
   logic [31:0] model_rdata = 32'd0;
   bit          chk_on = 1'b0;
   int          pass_cnt = 0;
   int          total_cnt = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
   endtask

   function automatic exp_t mk(input bit ready, en, we, done, err,
                               input logic [31:0] rd, input logic [ADDR_W-1:0] a,
                               input logic [31:0] wd);
      exp_t e;
      e.ready = ready; e.en = en; e.we = we; e.done = done; e.err = err;
      e.rdata = rd; e.a = a; e.wd = wd;
      return e;
   endfunction

   // Value returned by a load: select bytes arithmetically, extend by subtraction
   function automatic logic [31:0] model_load(input logic [31:0] w, input logic [1:0] sz,
                                              input bit zext, input logic [1:0] a);
      longint v;
      int bits, sh;
      if (sz == 2'd1)      begin bits = 16; sh = 16 * int'(a[1]); end
      else if (sz == 2'd2) begin bits = 8;  sh = 8 * int'(a);     end
      else return w;
      v = (longint'(w) >> sh) % (longint'(1) << bits);
      if (!zext && v >= (longint'(1) << (bits - 1))) v = v - (longint'(1) << bits);
      return v[31:0];
   endfunction

   // Word after a sub-word store: clear the target field, add the new value
   function automatic logic [31:0] model_merge(input logic [31:0] w, input logic [1:0] sz,
                                               input logic [1:0] a, input logic [31:0] wd);
      longint field, mask;
      int bits, sh;
      if (sz == 2'd1) begin bits = 16; sh = 16 * int'(a[1]); end
      else            begin bits = 8;  sh = 8 * int'(a);     end
      mask  = ((longint'(1) << bits) - 1) << sh;
      field = (longint'(wd) % (longint'(1) << bits)) << sh;
      return 32'((longint'(w) & ~mask) | field);
   endfunction

   // Per-cycle comparator against the model schedule (idle when empty)
   always @(negedge clk) begin
      if (chk_on) begin
         if (expq.size() > 0) cur = expq.pop_front();
         else                 cur = mk(1, 0, 0, 0, 0, model_rdata, '0, '0);
         chk("req_ready", 32'(bus.req_ready), 32'(cur.ready));
         chk("ram_en",    32'(bus.ram_en),    32'(cur.en));
         chk("ram_we",    32'(bus.ram_we),    32'(cur.we));
         chk("done",      32'(bus.done),      32'(cur.done));
         chk("err",       32'(bus.err),       32'(cur.err));
         chk("rdata",     bus.rdata,          cur.rdata);
         if (cur.en) chk("ram_addr",  32'(bus.ram_addr), 32'(cur.a));
         if (cur.we) chk("ram_wdata", bus.ram_wdata,     cur.wd);
      end
   end

   // Present one request in cycle 0, load the model schedule, return at the
   // earliest cycle a following request may be presented
   task automatic issue(input bit rd, input bit wr, input logic [1:0] sz,
                        input bit zext, input logic [31:0] a, input logic [31:0] wd);
      bit                conflict, mis, word, half;
      int                lat;
      logic [ADDR_W-1:0] wi;
      logic [31:0]       prev, res;
      @(negedge clk); #1;
      bus.req_valid   = 1'b1;
      bus.memRead     = rd;
      bus.memWrite    = wr;
      bus.memDataSize = sz;
      bus.memBitExt   = zext;
      bus.addr        = a;
      bus.wdata       = wd;
      conflict = rd && wr;
      word     = (sz == 2'd0) || (sz == 2'd3);
      half     = (sz == 2'd1);
      mis      = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
      mis      = (half && a[0]) || (word && (a[1:0] != 2'b00));
`endif
      wi   = a[ADDR_W+1:2];
      prev = model_rdata;
      lat  = 0;
      if (!rd && !wr) begin
         lat = 0;
      end else if (conflict || mis) begin
         expq.push_back(mk(0, 0, 0, 1, 1, prev, '0, '0));
         lat = 1;
      end else if (rd) begin
         res = model_load(ref_mem[wi], sz, zext, a[1:0]);
         expq.push_back(mk(0, 1, 0, 0, 0, prev, wi, '0));
         expq.push_back(mk(0, 0, 0, 0, 0, prev, '0, '0));
         expq.push_back(mk(0, 0, 0, 1, 0, res,  '0, '0));
         model_rdata = res;
         lat = 3;
      end else if (word) begin
         expq.push_back(mk(0, 1, 1, 0, 0, prev, wi, wd));
         expq.push_back(mk(0, 0, 0, 1, 0, prev, '0, '0));
         ref_mem[wi] = wd;
         lat = 2;
      end else begin
         res = model_merge(ref_mem[wi], sz, a[1:0], wd);
         expq.push_back(mk(0, 1, 0, 0, 0, prev, wi, '0));
         expq.push_back(mk(0, 0, 0, 0, 0, prev, '0, '0));
         expq.push_back(mk(0, 1, 1, 0, 0, prev, wi, res));
         expq.push_back(mk(0, 0, 0, 1, 0, prev, '0, '0));
         ref_mem[wi] = res;
         lat = 4;
      end
      @(negedge clk); #1;
      // Busy-time inputs must be ignored
      bus.req_valid = 1'b0;
      bus.memRead   = 1'b1;
      bus.memWrite  = 1'b1;
      bus.addr      = 32'hFFFF_FFFC;
      bus.wdata     = 32'h5A5A_5A5A;
      if (lat > 1) repeat (lat - 1) @(negedge clk);
   endtask

   initial begin
      for (int i = 0; i < DEPTH; i++) begin
         ram[i]     = 32'd0;
         ref_mem[i] = 32'd0;
      end
      bus.req_valid   = 1'b0;
      bus.memRead     = 1'b0;
      bus.memWrite    = 1'b0;
      bus.memDataSize = 2'd0;
      bus.memBitExt   = 1'b0;
      bus.addr        = 32'd0;
      bus.wdata       = 32'd0;

      // Reset values
      #2;
      chk("rst req_ready", 32'(bus.req_ready), 32'd1);
      chk("rst done",      32'(bus.done),      32'd0);
      chk("rst err",       32'(bus.err),       32'd0);
      chk("rst rdata",     bus.rdata,          32'd0);
      chk("rst ram_en",    32'(bus.ram_en),    32'd0);
      chk("rst ram_we",    32'(bus.ram_we),    32'd0);
      chk("rst ram_addr",  32'(bus.ram_addr),  32'd0);
      chk("rst ram_wdata", bus.ram_wdata,      32'd0);
      repeat (2) @(negedge clk);
      #1 rst_n = 1'b1;
      chk_on = 1'b1;

      // Word store then word load
      issue(0, 1, 2'd0, 0, 32'h10, 32'hDEADBEEF);
      issue(1, 0, 2'd0, 0, 32'h10, 32'h0);
      chk("lw 0x10", bus.rdata, 32'hDEADBEEF);

      // Byte and halfword loads with both extensions
      issue(0, 1, 2'd3, 0, 32'h20, 32'h80FF7F01);
      issue(1, 0, 2'd2, 0, 32'h23, 32'h0);
      chk("lb 0x23", bus.rdata, 32'hFFFFFF80);
      issue(1, 0, 2'd2, 1, 32'h23, 32'h0);
      chk("lbu 0x23", bus.rdata, 32'h00000080);
      issue(1, 0, 2'd1, 0, 32'h22, 32'h0);
      chk("lh 0x22", bus.rdata, 32'hFFFF80FF);
      issue(1, 0, 2'd1, 1, 32'h22, 32'h0);
      chk("lhu 0x22", bus.rdata, 32'h000080FF);
      issue(1, 0, 2'd2, 0, 32'h21, 32'h0);
      chk("lb 0x21", bus.rdata, 32'h0000007F);
      issue(1, 0, 2'd1, 0, 32'h20, 32'h0);
      chk("lh 0x20", bus.rdata, 32'h00007F01);

      // Sub-word stores as read-modify-write
      issue(0, 1, 2'd0, 0, 32'h30, 32'h11223344);
      issue(0, 1, 2'd2, 0, 32'h31, 32'h123456AA);
      chk("ram after sb", ram[12], 32'h1122AA44);
      issue(0, 1, 2'd1, 0, 32'h32, 32'h9999BEEF);
      issue(1, 0, 2'd0, 0, 32'h30, 32'h0);
      chk("lw after sh", bus.rdata, 32'hBEEFAA44);

      // Read+write conflict, then a request with neither op
      issue(1, 1, 2'd0, 0, 32'h30, 32'h0);
      issue(0, 0, 2'd0, 0, 32'h30, 32'h0);
      issue(1, 0, 2'd2, 1, 32'h33, 32'h0);
      chk("lbu 0x33", bus.rdata, 32'h000000BE);

      // Misaligned word/halfword accesses
      issue(0, 1, 2'd0, 0, 32'h04, 32'hCAFEF00D);
      issue(1, 0, 2'd0, 0, 32'h05, 32'h0);
`ifdef MEM_ALIGN_CHECK_EN
      chk("lw 0x05", bus.rdata, 32'h000000BE);
`else
      chk("lw 0x05", bus.rdata, 32'hCAFEF00D);
`endif
      issue(1, 0, 2'd1, 0, 32'h07, 32'h0);
`ifndef MEM_ALIGN_CHECK_EN
      chk("lh 0x07", bus.rdata, 32'hFFFFCAFE);
`endif

      // Reset during the RDW cycle of a byte store
      @(negedge clk); #1;
      bus.req_valid   = 1'b1;
      bus.memRead     = 1'b0;
      bus.memWrite    = 1'b1;
      bus.memDataSize = 2'd2;
      bus.addr        = 32'h30;
      bus.wdata       = 32'h00000055;
      expq.push_back(mk(0, 1, 0, 0, 0, model_rdata, 10'd12, '0));
      @(negedge clk); #1;
      bus.req_valid = 1'b0;
      @(posedge clk); #2;
      rst_n = 1'b0;
      expq.delete();
      model_rdata = 32'd0;
      #1;
      chk("mid-rst req_ready", 32'(bus.req_ready), 32'd1);
      chk("mid-rst done",      32'(bus.done),      32'd0);
      chk("mid-rst ram_en",    32'(bus.ram_en),    32'd0);
      chk("mid-rst ram_we",    32'(bus.ram_we),    32'd0);
      chk("mid-rst rdata",     bus.rdata,          32'd0);
      chk("mid-rst ram_addr",  32'(bus.ram_addr),  32'd0);
      chk("mid-rst ram_wdata", bus.ram_wdata,      32'd0);
      @(negedge clk); #1;
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      chk("ram kept", ram[12], 32'hBEEFAA44);
      issue(1, 0, 2'd0, 0, 32'h30, 32'h0);
      chk("lw after rst", bus.rdata, 32'hBEEFAA44);
      issue(0, 1, 2'd2, 0, 32'h30, 32'h00000055);
      chk("sb after rst", ram[12], 32'hBEEFAA55);

      repeat (3) @(negedge clk);
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
`default_nettype wire
